reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Ordered reset-release controller for fabric reset domains. Sits downstream of the fabric reset synchroniser, which supplies RESET_N. Releases a configurable number of domain resets one at a time, waits for each domain's ready acknowledge and enforces a minimum stagger between releases. Supervises domains while running, and asserts domain resets in reverse order on a software request or on a fault.

## Interface
- NUM_DOMAINS, 4: number of sequenced domains (1–16).
- STAGGER_CYCLES, 16: cycles from a domain's ack to the next release (≥1).
- ACK_TIMEOUT, 64: cycles allowed for a domain to ack after release (≥2).
- CLK  in  1  single clock for all logic.
- RESET_N  in  1  asynchronous active-low reset. Clock is CLK, reset is RESET_N; one clock, reset asynchronous and active-low.
- START  in  1  level, synchronous to CLK. High means upstream is ready to begin sequencing.
- SW_RESET_REQ  in  1  single-cycle pulse. Requests an orderly shutdown; also clears FAULT.
- DOMAIN_READY  in  NUM_DOMAINS  per-domain ack, synchronous to CLK.
- DOMAIN_RESET_N  out  NUM_DOMAINS  per-domain active-low resets, registered.
- ALL_READY  out  1  high only in RUN.
- BUSY  out  1  high in RELEASE_WAIT, GAP, SHUTDOWN.
- FAULT  out  1  sticky fault flag.
- FAULT_DOMAIN  out  4  index of the faulting domain; valid while FAULT=1.

## Operation
- States: IDLE, RELEASE_WAIT, GAP, RUN, SHUTDOWN, FAULT_ST. Index register idx; one shared down-counter.
- RESET_N low: state IDLE, idx=0, all outputs 0 (DOMAIN_RESET_N all 0), counter 0. Applies immediately without a clock.
- IDLE, START=1:
  - set DOMAIN_RESET_N[0]=1, load counter with ACK_TIMEOUT, go to RELEASE_WAIT.
- RELEASE_WAIT:
  - DOMAIN_READY[idx]=1 and idx=N-1: go to RUN.
  - DOMAIN_READY[idx]=1 otherwise: load counter with STAGGER_CYCLES-1, go to GAP.
  - Counter reaches 0 before ack: go to FAULT_ST with FAULT_DOMAIN=idx.
  - Ack and expiry on the same edge: ack wins.
- GAP: decrement the counter. At 0: idx+1, set DOMAIN_RESET_N[idx+1]=1, reload ACK_TIMEOUT, go to RELEASE_WAIT.
- RUN:
  - SW_RESET_REQ or START=0: go to SHUTDOWN.
  - Otherwise, any DOMAIN_READY low: go to FAULT_ST with FAULT_DOMAIN = lowest low index.
  - SW_RESET_REQ takes priority over a ready drop on the same edge.
- SHUTDOWN:
  - Clear DOMAIN_RESET_N bits one per edge, from N-1 down to 0. The first clear happens on the edge that enters SHUTDOWN.
  - Go to IDLE on the edge after bit 0 is cleared.
  - DOMAIN_READY is ignored in this state.
- START=0 in RELEASE_WAIT or GAP: all DOMAIN_RESET_N=0 on the next edge, go to IDLE, no fault.
- SW_RESET_REQ in RELEASE_WAIT or GAP: same behaviour as START=0.
- FAULT_ST:
  - All DOMAIN_RESET_N=0 on the entry edge; FAULT=1.
  - Leaves only on SW_RESET_REQ: FAULT=0, go to IDLE. START is ignored.
- Counter width: clog2(max(ACK_TIMEOUT, STAGGER_CYCLES)+1). No wrap; the counter holds at 0.

## Timing
- START sampled high at edge k → DOMAIN_RESET_N[0]=1 after edge k.
- Release of domain i at edge r, ack sampled at edge a → release of domain i+1 at edge a+STAGGER_CYCLES.
- Timeout: ack not sampled by edge r+ACK_TIMEOUT-1 → FAULT=1 after edge r+ACK_TIMEOUT.
- ALL_READY rises on the edge sampling the last ack. It falls on the edge entering SHUTDOWN or FAULT_ST.
- SHUTDOWN lasts NUM_DOMAINS edges; BUSY drops on the edge entering IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package reset_sequencer_pkg: state enum, FAULT_DOMAIN width constant (4), max domain count (16).
- One sub-module, seq_timer: loadable down-counter with a zero flag, shared between the timeout and stagger functions.
- The FSM and the domain reset register live in the top module.

## Test plan
Parameters for all cases: N=4, STAGGER_CYCLES=16, ACK_TIMEOUT=64.
- Nominal sequence: START high at edge 0; each domain acks 3 edges after its release → releases at edges 1, 20, 39, 58; ALL_READY=1 at edge 61.
- Timeout: domain 2 never acks → released at 39; FAULT=1 and FAULT_DOMAIN=2 at edge 103; DOMAIN_RESET_N=0000.
- Shutdown: SW_RESET_REQ in RUN → DOMAIN_RESET_N goes 0111, 0011, 0001, 0000 on successive edges; ALL_READY=0 on the first of these; BUSY=0 after the 4th.
- Ready drop: DOMAIN_READY[1] drops in RUN → FAULT_DOMAIN=1 on the next edge. Toggling START leaves FAULT set. SW_RESET_REQ clears it → IDLE.
- Abort: START low during GAP after domain 1 → DOMAIN_RESET_N=0000 next edge, IDLE, FAULT=0.
- Corner cases:
  - Ack on the expiry edge → no fault.
  - RESET_N low mid-RELEASE_WAIT → all outputs 0 immediately with CLK stopped.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared state encoding, widths and helpers for the reset sequencer
package reset_sequencer_pkg;
  localparam int FDW = 4;
  localparam int MAX_DOMAINS = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE_WAIT,
    S_GAP,
    S_RUN,
    S_SHUTDOWN,
    S_FAULT
  } state_t;
  function automatic logic [FDW-1:0] lowest_low(input logic [MAX_DOMAINS-1:0] v);
    logic [FDW-1:0] r;
    r = '0;
    for (int i = MAX_DOMAINS - 1; i >= 0; i--) if (!v[i]) r = FDW'(i);
    return r;
  endfunction
endpackage

// File: rtl/reset_sequencer_timer.sv
// seq_timer: loadable down-counter that holds at zero, shared by ack timeout and stagger
module seq_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  end
  assign zero = count == '0;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered domain reset release with ack timeout, stagger, supervision and shutdown
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int STAGGER_CYCLES = 16,
  parameter int ACK_TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   sw_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   all_ready,
  output logic                   busy,
  output logic                   fault,
  output logic [FDW-1:0]         fault_domain
);
  localparam int MAXC = ACK_TIMEOUT > STAGGER_CYCLES ? ACK_TIMEOUT : STAGGER_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DOMAINS - 1);
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [NUM_DOMAINS-1:0] drn_nx;
  logic fault_nx;
  logic [FDW-1:0] fdom_nx;
  logic load, dec, zero, abort;
  logic [CW-1:0] load_val, count;
  logic [MAX_DOMAINS-1:0] rdy_pad;
  seq_timer #(.W(CW)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .load_val(load_val),
    .dec(dec),
    .count(count),
    .zero(zero)
  );
  assign abort = !start || sw_reset_req;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    drn_nx = domain_reset_n;
    fault_nx = fault;
    fdom_nx = fault_domain;
    load = 1'b0;
    load_val = '0;
    dec = 1'b0;
    rdy_pad = '1;
    rdy_pad[NUM_DOMAINS-1:0] = domain_ready;
    case (state)
      S_IDLE: begin
        idx_nx = '0;
        if (start) begin
          drn_nx[0] = 1'b1;
          load = 1'b1;
          load_val = CW'(ACK_TIMEOUT);
          state_nx = S_RELEASE_WAIT;
        end
      end
      S_RELEASE_WAIT: begin
        if (abort) begin
          drn_nx = '0;
          idx_nx = '0;
          state_nx = S_IDLE;
        end else if (domain_ready[idx]) begin
          state_nx = idx == LAST ? S_RUN : S_GAP;
          load = idx != LAST;
          load_val = CW'(STAGGER_CYCLES - 1);
        end else if (count <= CW'(1)) begin
          // this edge would take the counter to zero: the ack window has expired
          drn_nx = '0;
          fault_nx = 1'b1;
          fdom_nx = FDW'(idx);
          state_nx = S_FAULT;
        end else dec = 1'b1;
      end
      S_GAP: begin
        if (abort) begin
          drn_nx = '0;
          idx_nx = '0;
          state_nx = S_IDLE;
        end else if (zero) begin
          idx_nx = idx + IW'(1);
          drn_nx[idx+IW'(1)] = 1'b1;
          load = 1'b1;
          load_val = CW'(ACK_TIMEOUT);
          state_nx = S_RELEASE_WAIT;
        end else dec = 1'b1;
      end
      S_RUN: begin
        if (abort) begin
          drn_nx[LAST] = 1'b0;
          state_nx = S_SHUTDOWN;
        end else if (!(&domain_ready)) begin
          drn_nx = '0;
          fault_nx = 1'b1;
          fdom_nx = lowest_low(rdy_pad);
          state_nx = S_FAULT;
        end
      end
      S_SHUTDOWN: begin
        // idx tracks the bit cleared on the previous edge
        if (idx == '0) state_nx = S_IDLE;
        else begin
          idx_nx = idx - IW'(1);
          drn_nx[idx-IW'(1)] = 1'b0;
        end
      end
      S_FAULT: begin
        drn_nx = '0;
        if (sw_reset_req) begin
          fault_nx = 1'b0;
          idx_nx = '0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        drn_nx = '0;
        idx_nx = '0;
        state_nx = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx <= '0;
      domain_reset_n <= '0;
      all_ready <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
      fault_domain <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      domain_reset_n <= drn_nx;
      all_ready <= state_nx == S_RUN;
      busy <= state_nx inside {S_RELEASE_WAIT, S_GAP, S_SHUTDOWN};
      fault <= fault_nx;
      fault_domain <= fdom_nx;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release timing, timeout, shutdown, fault and abort
module tb_reset_sequencer;
  logic clk = 1'b0;
  bit clk_run = 1'b1;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic sw_reset_req = 1'b0;
  logic [3:0] domain_ready = '0;
  logic [3:0] domain_reset_n;
  logic all_ready, busy, fault;
  logic [3:0] fault_domain;
  int n_chk = 0;
  int n_err = 0;
  int e = 0;
  int rel_tab[4] = '{1, 20, 39, 58};
  int rel_mask[4] = '{1, 3, 7, 15};
  reset_sequencer #(
    .NUM_DOMAINS(4),
    .STAGGER_CYCLES(16),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .sw_reset_req(sw_reset_req),
    .domain_ready(domain_ready),
    .domain_reset_n(domain_reset_n),
    .all_ready(all_ready),
    .busy(busy),
    .fault(fault),
    .fault_domain(fault_domain)
  );
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic run_to(input int t);
    while (e < t) step();
  endtask
  task automatic do_reset();
    start = 1'b0;
    sw_reset_req = 1'b0;
    domain_ready = '0;
    reset_n = 1'b0;
    #3;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask
  // edge 0 drives START high; each domain acks three edges after its release
  task automatic seq(input int upto, input int no_ack);
    step();
    e = 0;
    start = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (rel_tab[d] > upto) return;
      run_to(rel_tab[d]);
      check($sformatf("release%0d", d), domain_reset_n, rel_mask[d]);
      if (d == no_ack || rel_tab[d] + 2 > upto) return;
      run_to(rel_tab[d] + 2);
      domain_ready[d] = 1'b1;
    end
    run_to(upto);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_drn", domain_reset_n, 0);
    check("rst_busy", busy, 0);
    check("rst_all_ready", all_ready, 0);
    check("rst_fault", fault, 0);
    check("rst_fdom", fault_domain, 0);
    seq(60, -1);
    check("nom_pre_all_ready", all_ready, 0);
    check("nom_pre_busy", busy, 1);
    step();
    check("nom_all_ready", all_ready, 1);
    check("nom_busy", busy, 0);
    check("nom_drn", domain_reset_n, 15);
    do_reset();
    seq(39, 2);
    run_to(102);
    check("to_pre_fault", fault, 0);
    check("to_pre_drn", domain_reset_n, 7);
    run_to(103);
    check("to_fault", fault, 1);
    check("to_fdom", fault_domain, 2);
    check("to_drn", domain_reset_n, 0);
    check("to_busy", busy, 0);
    start = 1'b0;
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    check("to_clear", fault, 0);
    do_reset();
    seq(39, 2);
    run_to(102);
    domain_ready[2] = 1'b1;
    run_to(103);
    check("expiry_ack_fault", fault, 0);
    check("expiry_ack_busy", busy, 1);
    check("expiry_ack_drn", domain_reset_n, 7);
    run_to(118);
    check("expiry_pre_rel3", domain_reset_n, 7);
    run_to(119);
    check("expiry_rel3", domain_reset_n, 15);
    run_to(121);
    domain_ready[3] = 1'b1;
    run_to(122);
    check("expiry_all_ready", all_ready, 1);
    do_reset();
    seq(61, -1);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    check("sd_drn0", domain_reset_n, 7);
    check("sd_all_ready", all_ready, 0);
    check("sd_busy0", busy, 1);
    step();
    check("sd_drn1", domain_reset_n, 3);
    step();
    check("sd_drn2", domain_reset_n, 1);
    step();
    start = 1'b0;
    check("sd_drn3", domain_reset_n, 0);
    check("sd_busy3", busy, 1);
    step();
    check("sd_busy4", busy, 0);
    check("sd_fault", fault, 0);
    step();
    check("sd_idle_drn", domain_reset_n, 0);
    do_reset();
    seq(61, -1);
    domain_ready = 4'b0101;
    step();
    check("drop_fault", fault, 1);
    check("drop_fdom", fault_domain, 1);
    check("drop_drn", domain_reset_n, 0);
    check("drop_all_ready", all_ready, 0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    check("drop_sticky", fault, 1);
    check("drop_sticky_fdom", fault_domain, 1);
    check("drop_sticky_drn", domain_reset_n, 0);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    start = 1'b0;
    check("drop_clear", fault, 0);
    check("drop_clear_busy", busy, 0);
    do_reset();
    seq(30, -1);
    check("abort_pre_busy", busy, 1);
    start = 1'b0;
    step();
    check("abort_drn", domain_reset_n, 0);
    check("abort_busy", busy, 0);
    check("abort_fault", fault, 0);
    step();
    check("abort_idle_drn", domain_reset_n, 0);
    do_reset();
    seq(39, 2);
    run_to(41);
    check("ar_pre_drn", domain_reset_n, 7);
    check("ar_pre_busy", busy, 1);
    clk_run = 1'b0;
    #10;
    reset_n = 1'b0;
    #1;
    check("ar_drn", domain_reset_n, 0);
    check("ar_busy", busy, 0);
    check("ar_all_ready", all_ready, 0);
    check("ar_fault", fault, 0);
    start = 1'b0;
    domain_ready = '0;
    #20;
    reset_n = 1'b1;
    clk_run = 1'b1;
    step();
    check("ar_after_drn", domain_reset_n, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
